operand_exec: RTL and testbench

Command-driven execute stage that sits beside the register file: it accepts one ALU command at a time over a valid/ready handshake, reads both source operands through the file's two read ports, computes a 32-bit result, and writes it back through the file's write port. It owns all traffic on the file's `read_*` and `write_*` inputs. Upstream command sources see only the handshake and a completion pulse.

---
 rtl/operand_exec.sv | 164 ++++++++++++++++
 tb/tb_operand_exec.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_exec.sv
`default_nettype none
// ============================================================================
// operand_exec : register-file-side execute stage (read, compute, write back)
// Build option  : define OPERAND_EXEC_SAT_EN for unsigned saturating ADD/SUB
// Revision      : 1.0
// ============================================================================
module operand_exec #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [2:0]  cmd_op_in,
  input  logic [7:0]  cmd_src0_in,
  input  logic [7:0]  cmd_src1_in,
  input  logic [7:0]  cmd_dst_in,
  output logic [7:0]  read_addr0_out,
  output logic [7:0]  read_addr1_out,
  output logic        read_out,
  input  logic [31:0] read_data0_in,
  input  logic [31:0] read_data1_in,
  output logic [7:0]  write_addr_out,
  output logic        write_out,
  output logic [31:0] write_data_out,
  output logic        done_out,
  output logic        err_out,
  output logic [15:0] cmd_count_out,
  input  logic        debugen_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  // Nine bits so a depth of 256 never flags an 8-bit index.
  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);

  state_t      state, state_nxt;
  logic [2:0]  op;
  logic [7:0]  src0, src1, dst;
  logic [31:0] opnd0, opnd1, result, alu;
  logic [15:0] cmd_count;
  logic        err;
  logic        accept;
  logic        idx_bad;

`ifdef OPERAND_EXEC_SAT_EN
  logic [32:0] sum, diff;
`endif

  assign accept  = cmd_valid_in & cmd_ready_out;
  assign idx_bad = ({1'b0, cmd_src0_in} >= DEPTH) | ({1'b0, cmd_src1_in} >= DEPTH) |
                   ({1'b0, cmd_dst_in} >= DEPTH);

  always_comb begin
    state_nxt     = state;
    cmd_ready_out = 1'b0;
    read_out      = 1'b0;
    write_out     = 1'b0;
    done_out      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_out = 1'b1;
        if (cmd_valid_in) state_nxt = READ;
      end
      READ: begin
        read_out  = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
        write_out = 1'b1;
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
`ifdef OPERAND_EXEC_SAT_EN
    sum  = {1'b0, opnd0} + {1'b0, opnd1};
    diff = {1'b0, opnd0} - {1'b0, opnd1};
`endif
    alu = '0;
    case (op)
`ifdef OPERAND_EXEC_SAT_EN
      OP_ADD: alu = sum[32]  ? '1 : sum[31:0];
      OP_SUB: alu = diff[32] ? '0 : diff[31:0];
`else
      OP_ADD: alu = opnd0 + opnd1;
      OP_SUB: alu = opnd0 - opnd1;
`endif
      OP_AND: alu = opnd0 & opnd1;
      OP_OR:  alu = opnd0 | opnd1;
      OP_XOR: alu = opnd0 ^ opnd1;
      OP_SHL: alu = opnd0 << opnd1[4:0];
      OP_SHR: alu = opnd0 >> opnd1[4:0];
      OP_MOV: alu = opnd0;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op        <= '0;
      src0      <= '0;
      src1      <= '0;
      dst       <= '0;
      opnd0     <= '0;
      opnd1     <= '0;
      result    <= '0;
      cmd_count <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op   <= cmd_op_in;
        src0 <= cmd_src0_in;
        src1 <= cmd_src1_in;
        dst  <= cmd_dst_in;
        if (idx_bad) err <= 1'b1;
      end
      if (state == READ) begin
        opnd0 <= read_data0_in;
        opnd1 <= read_data1_in;
      end
      if (state == EXEC) result <= alu;
      if (state == WB) cmd_count <= cmd_count + 16'd1;
    end
  end

  // Latched source indices double as the read-port addresses and hold between reads.
  assign read_addr0_out = src0;
  assign read_addr1_out = src1;
  assign write_addr_out = dst;
  assign write_data_out = result;
  assign err_out        = err;
  assign cmd_count_out  = cmd_count;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && state == WB && debugen_in)
      $write("operand_exec: op=%0d src0=%0d src1=%0d dst=%0d a=%h b=%h res=%h\n",
             op, src0, src1, dst, opnd0, opnd1, result);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_exec.sv
`default_nettype none
// tb_operand_exec : directed and randomized checks of operand_exec against a
// command-level register-file model.
module tb_operand_exec;

  localparam int DEPTH = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_src0 = '0, cmd_src1 = '0, cmd_dst = '0;
  logic [7:0]  read_addr0, read_addr1, write_addr;
  logic        read_en, write_en, done, err;
  logic [31:0] read_data0, read_data1, write_data;
  logic [15:0] cmd_count;
  logic        debugen = 1'b0;

  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  logic [31:0] rf   [0:255];
  logic [31:0] gold [0:255];
  int          exp_count = 0;
  logic        exp_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  operand_exec #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
    .cmd_op_in(cmd_op), .cmd_src0_in(cmd_src0), .cmd_src1_in(cmd_src1), .cmd_dst_in(cmd_dst),
    .read_addr0_out(read_addr0), .read_addr1_out(read_addr1), .read_out(read_en),
    .read_data0_in(read_data0), .read_data1_in(read_data1),
    .write_addr_out(write_addr), .write_out(write_en), .write_data_out(write_data),
    .done_out(done), .err_out(err), .cmd_count_out(cmd_count), .debugen_in(debugen)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational read, out-of-range writes ignored.
  assign read_data0 = (int'(read_addr0) < DEPTH) ? rf[read_addr0] : 32'hDEADBEEF;
  assign read_data1 = (int'(read_addr1) < DEPTH) ? rf[read_addr1] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (write_en && int'(write_addr) < DEPTH) rf[write_addr] <= write_data;
  end

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned sa = 64'(a);
    longint unsigned sb = 64'(b);
    case (op)
`ifdef OPERAND_EXEC_SAT_EN
      3'd0: return (sa + sb > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sa + sb);
      3'd1: return (sb > sa) ? 32'h0 : 32'(sa - sb);
`else
      3'd0: return 32'(sa + sb);
      3'd1: return 32'(sa - sb);
`endif
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % 32);
      3'd6: return a >> (b % 32);
      default: return a;
    endcase
  endfunction

  task automatic model_cmd(input logic [2:0] op, input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] d, output logic [31:0] exp);
    logic [31:0] a, b;
    a = (int'(s0) < DEPTH) ? gold[s0] : 32'hDEADBEEF;
    b = (int'(s1) < DEPTH) ? gold[s1] : 32'hDEADBEEF;
    exp = alu_ref(op, a, b);
    if (int'(d) < DEPTH) gold[d] = exp;
    if (int'(s0) >= DEPTH || int'(s1) >= DEPTH || int'(d) >= DEPTH) exp_err = 1'b1;
    exp_count = (exp_count + 1) % 65536;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    gold[a] = d;
  endtask

  // Issues one command from IDLE and records what the DUT did over the following cycles.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] d, output int wr_cnt, output int wr_cyc,
                         output logic [7:0] wa, output logic [31:0] wd, output int done_cnt,
                         output bit rd_ok);
    int t;
    @(negedge clk);
    cmd_op = op; cmd_src0 = s0; cmd_src1 = s1; cmd_dst = d; cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wr_cnt = 0; wr_cyc = -1; wa = '0; wd = '0; done_cnt = 0; rd_ok = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1 && read_en === 1'b1 && read_addr0 === s0 && read_addr1 === s1) rd_ok = 1;
      if (write_en === 1'b1) begin
        wr_cnt++; wr_cyc = k; wa = write_addr; wd = write_data;
      end
      if (done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #3;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    vectors++; if (read_en !== 1'b0) begin miscompares++; $display("FAIL rst_read: got %b want 0", read_en); end
    vectors++; if (write_en !== 1'b0) begin miscompares++; $display("FAIL rst_write: got %b want 0", write_en); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
    vectors++; if (cmd_count !== 16'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", cmd_count); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add;
    int wc, wcy, dc; logic [7:0] wa; logic [31:0] wd, exp; bit rd;
    preload(8'd1, 32'd5); preload(8'd2, 32'd7);
    model_cmd(3'd0, 8'd1, 8'd2, 8'd3, exp);
    debugen = 1'b1;
    run_cmd(3'd0, 8'd1, 8'd2, 8'd3, wc, wcy, wa, wd, dc, rd);
    debugen = 1'b0;
    vectors++; if (wc !== 1 || wcy !== 3) begin miscompares++; $display("FAIL add_write_timing: count=%0d cycle=%0d want 1 at 3", wc, wcy); end
    vectors++; if (wa !== 8'd3) begin miscompares++; $display("FAIL add_addr: got %0d want 3", wa); end
    vectors++; if (wd !== exp || wd !== 32'd12) begin miscompares++; $display("FAIL add_data: got %h want %h", wd, exp); end
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL add_done: pulses=%0d want 1", dc); end
    vectors++; if (!rd) begin miscompares++; $display("FAIL add_read_phase: got 0 want 1"); end
    vectors++; if (cmd_count !== 16'(exp_count)) begin miscompares++; $display("FAIL add_count: got %0d want %0d", cmd_count, exp_count); end
    // Overflow: wraps to 1 by default, saturates with the option defined.
    preload(8'd1, 32'hFFFF_FFFF); preload(8'd2, 32'd2);
    model_cmd(3'd0, 8'd1, 8'd2, 8'd4, exp);
    run_cmd(3'd0, 8'd1, 8'd2, 8'd4, wc, wcy, wa, wd, dc, rd);
    vectors++; if (wd !== exp) begin miscompares++; $display("FAIL add_overflow: got %h want %h", wd, exp); end
  endtask

  task automatic test_shift;
    int wc, wcy, dc; logic [7:0] wa; logic [31:0] wd, exp; bit rd;
    preload(8'd6, 32'h8000_0001); preload(8'd7, 32'h21);
    model_cmd(3'd6, 8'd6, 8'd7, 8'd10, exp);
    run_cmd(3'd6, 8'd6, 8'd7, 8'd10, wc, wcy, wa, wd, dc, rd);
    vectors++; if (wd !== exp || wd !== 32'h4000_0000) begin miscompares++; $display("FAIL shr: got %h want %h", wd, exp); end
    model_cmd(3'd5, 8'd6, 8'd7, 8'd11, exp);
    run_cmd(3'd5, 8'd6, 8'd7, 8'd11, wc, wcy, wa, wd, dc, rd);
    vectors++; if (wd !== exp || wd !== 32'h0000_0002) begin miscompares++; $display("FAIL shl: got %h want %h", wd, exp); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_a, exp_b;
    preload(8'd1, 32'd5); preload(8'd2, 32'd7);
    model_cmd(3'd0, 8'd1, 8'd2, 8'd3, exp_a);
    model_cmd(3'd1, 8'd3, 8'd1, 8'd5, exp_b);
    @(negedge clk);
    cmd_op = 3'd0; cmd_src0 = 8'd1; cmd_src1 = 8'd2; cmd_dst = 8'd3; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 3'd1; cmd_src0 = 8'd3; cmd_src1 = 8'd1; cmd_dst = 8'd5;
    for (int k = 1; k <= 4; k++) begin
      vectors++; if (cmd_ready !== (k == 4)) begin miscompares++; $display("FAIL b2b_ready_k%0d: got %b want %b", k, cmd_ready, k == 4); end
      if (k == 3) begin
        vectors++; if (write_data !== exp_a) begin miscompares++; $display("FAIL b2b_first: got %h want %h", write_data, exp_a); end
      end
      @(posedge clk); #1;
    end
    vectors++; if (read_en !== 1'b1 || read_addr0 !== 8'd3) begin miscompares++; $display("FAIL b2b_second_accept: read=%b addr=%0d want 1,3", read_en, read_addr0); end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++; if (write_en !== 1'b1 || write_addr !== 8'd5 || write_data !== exp_b || exp_b !== 32'd7)
      begin miscompares++; $display("FAIL b2b_second: we=%b addr=%0d data=%h want 1,5,%h", write_en, write_addr, write_data, exp_b); end
    @(posedge clk); #1;
    vectors++; if (cmd_count !== 16'(exp_count)) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", cmd_count, exp_count); end
  endtask

  task automatic test_illegal;
    int wc, wcy, dc; logic [7:0] wa; logic [31:0] wd, exp; bit rd;
    model_cmd(3'd0, 8'd1, 8'd2, 8'd200, exp);
    run_cmd(3'd0, 8'd1, 8'd2, 8'd200, wc, wcy, wa, wd, dc, rd);
    vectors++; if (dc !== 1 || wa !== 8'd200) begin miscompares++; $display("FAIL illegal_complete: done=%0d addr=%0d want 1,200", dc, wa); end
    vectors++; if (err !== exp_err || err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b want 1", err); end
    model_cmd(3'd7, 8'd1, 8'd0, 8'd8, exp);
    run_cmd(3'd7, 8'd1, 8'd0, 8'd8, wc, wcy, wa, wd, dc, rd);
    vectors++; if (wd !== exp || dc !== 1) begin miscompares++; $display("FAIL illegal_next: data=%h done=%0d want %h,1", wd, dc, exp); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_midcmd;
    int wc, wcy, dc, bad; logic [7:0] wa; logic [31:0] wd, exp; bit rd;
    preload(8'd1, 32'd3); preload(8'd2, 32'd4);
    @(negedge clk);
    cmd_op = 3'd0; cmd_src0 = 8'd1; cmd_src1 = 8'd2; cmd_dst = 8'd9; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    exp_count = 0; exp_err = 1'b0;
    vectors++; if (cmd_ready !== 1'b1 || read_en !== 1'b0) begin miscompares++; $display("FAIL midrst_hs: ready=%b read=%b want 1,0", cmd_ready, read_en); end
    vectors++; if (write_en !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_wb: write=%b done=%b want 0,0", write_en, done); end
    vectors++; if (err !== 1'b0 || cmd_count !== 16'd0) begin miscompares++; $display("FAIL midrst_state: err=%b count=%0d want 0,0", err, cmd_count); end
    vectors++; if (write_data !== 32'd0 || write_addr !== 8'd0 || read_addr0 !== 8'd0)
      begin miscompares++; $display("FAIL midrst_regs: wd=%h wa=%0d ra=%0d want 0", write_data, write_addr, read_addr0); end
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (write_en !== 1'b0 || done !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL midrst_abort: stray cycles=%0d want 0", bad); end
    @(negedge clk);
    reset = 1'b1;
    model_cmd(3'd0, 8'd1, 8'd2, 8'd9, exp);
    run_cmd(3'd0, 8'd1, 8'd2, 8'd9, wc, wcy, wa, wd, dc, rd);
    vectors++; if (wd !== exp || wd !== 32'd7 || dc !== 1) begin miscompares++; $display("FAIL midrst_after: data=%h done=%0d want %h,1", wd, dc, exp); end
    vectors++; if (cmd_count !== 16'(exp_count)) begin miscompares++; $display("FAIL midrst_count: got %0d want %0d", cmd_count, exp_count); end
  endtask

  task automatic test_random;
    int wc, wcy, dc; logic [7:0] wa, s0, s1, d; logic [31:0] wd, exp; logic [2:0] op; bit rd;
    for (int i = 0; i < DEPTH; i++) preload(8'(i), $urandom);
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      s0 = 8'($urandom_range(0, DEPTH - 1));
      s1 = ($urandom_range(0, 4) == 0) ? s0 : 8'($urandom_range(0, DEPTH - 1));
      d  = ($urandom_range(0, 4) == 0) ? s1 : 8'($urandom_range(0, DEPTH - 1));
      model_cmd(op, s0, s1, d, exp);
      run_cmd(op, s0, s1, d, wc, wcy, wa, wd, dc, rd);
      vectors++; if (wd !== exp || wa !== d || wc !== 1 || dc !== 1)
        begin miscompares++; $display("FAIL rand_%0d op%0d: data=%h addr=%0d wr=%0d done=%0d want %h,%0d,1,1", n, op, wd, wa, wc, dc, exp, d); end
      vectors++; if (cmd_count !== 16'(exp_count)) begin miscompares++; $display("FAIL rand_count_%0d: got %0d want %0d", n, cmd_count, exp_count); end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_shift;
    test_back_to_back;
    test_illegal;
    test_reset_midcmd;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
